// File: rtl/iob_pfsm_input_cond.sv
// Input conditioning for the PFSM: per-bit 2-FF synchronizer, debounce filter,
// and level/edge qualifier with sticky event capture feeding input_ports.
module iob_pfsm_input_cond #(
  parameter int INPUT_W    = 4,
  parameter int DEBOUNCE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cke_i,
  input  logic [INPUT_W-1:0]    raw_i,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles_i,
  input  logic [2*INPUT_W-1:0]  mode_i,
  input  logic [INPUT_W-1:0]    clear_i,
  output logic [INPUT_W-1:0]    stable_o,
  output logic [INPUT_W-1:0]    input_ports_o
);

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

  logic [INPUT_W-1:0]    sync1_q;
  logic [INPUT_W-1:0]    sync2_q;
  logic [INPUT_W-1:0]    stable_q;
  logic [INPUT_W-1:0]    stable_d;
  logic [INPUT_W-1:0]    flag_q;
  logic [INPUT_W-1:0]    flag_d;
  logic [DEBOUNCE_W-1:0] cnt_q [INPUT_W];
  logic [DEBOUNCE_W-1:0] cnt_d [INPUT_W];

  // Debounce and event qualification; >= lets a lowered threshold act immediately
  // and keeps the counter from ever wrapping.
  always_comb begin
    logic upd;
    logic evt;
    stable_d = stable_q;
    flag_d   = flag_q;
    upd      = 1'b0;
    evt      = 1'b0;
    for (int i = 0; i < INPUT_W; i++) begin
      upd      = 1'b0;
      evt      = 1'b0;
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= debounce_cycles_i) begin
          upd         = 1'b1;
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      unique case (mode_i[2*i +: 2])
        MODE_RISE: evt = upd & sync2_q[i];
        MODE_FALL: evt = upd & ~sync2_q[i];
        MODE_BOTH: evt = upd;
        default:   evt = 1'b0;
      endcase
      // Set beats clear so an event coinciding with a clear is never lost.
      if (evt) begin
        flag_d[i] = 1'b1;
      end else if (clear_i[i] && (mode_i[2*i +: 2] != MODE_LEVEL)) begin
        flag_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      flag_q   <= '0;
      for (int i = 0; i < INPUT_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cke_i) begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    input_ports_o = flag_q;
    for (int i = 0; i < INPUT_W; i++) begin
      if (mode_i[2*i +: 2] == MODE_LEVEL) begin
        input_ports_o[i] = stable_q[i];
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: tb/tb_iob_pfsm_input_cond.sv
// Directed bench for iob_pfsm_input_cond: history-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_iob_pfsm_input_cond;

  localparam int IW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          cke;
  logic [IW-1:0] raw;
  logic [DW-1:0] ncyc;
  logic [2*IW-1:0] mode;
  logic [IW-1:0] clr;
  logic [IW-1:0] stable;
  logic [IW-1:0] ports;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  iob_pfsm_input_cond #(.INPUT_W(IW), .DEBOUNCE_W(DW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cke_i            (cke),
    .raw_i            (raw),
    .debounce_cycles_i(ncyc),
    .mode_i           (mode),
    .clear_i          (clr),
    .stable_o         (stable),
    .input_ports_o    (ports)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: a bit's stable level flips once the last N+1 synchronized
  // samples all disagree with it; frozen entirely when cke is low.
  bit m_p1 [IW];
  bit m_p2 [IW];
  bit m_s  [IW];
  bit m_f  [IW];
  bit hist [IW][$];

  initial begin
    bit cur;
    bit upd;
    bit ev;
    int n;
    int sz;
    logic [1:0] m;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < IW; i++) begin
          m_p1[i] = 0; m_p2[i] = 0; m_s[i] = 0; m_f[i] = 0;
          hist[i].delete();
        end
      end else if (cke) begin
        for (int i = 0; i < IW; i++) begin
          cur = m_p2[i];
          n = int'(ncyc);
          m = mode[2*i +: 2];
          hist[i].push_back(cur);
          if (hist[i].size() > 64) void'(hist[i].pop_front());
          sz = hist[i].size();
          upd = (sz >= n + 1);
          for (int j = 0; j <= n && upd; j++)
            if (hist[i][sz-1-j] == m_s[i]) upd = 0;
          ev = upd && ((m == 2'b01 && cur) || (m == 2'b10 && !cur) || m == 2'b11);
          if (upd) m_s[i] = cur;
          if (ev) m_f[i] = 1;
          else if (clr[i] && m != 2'b00) m_f[i] = 0;
          m_p2[i] = m_p1[i];
          m_p1[i] = raw[i];
        end
      end
    end
  end

  initial begin
    logic [IW-1:0] es;
    logic [IW-1:0] ep;
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int i = 0; i < IW; i++) begin
          es[i] = m_s[i];
          ep[i] = (mode[2*i +: 2] == 2'b00) ? m_s[i] : m_f[i];
        end
        checks++;
        if (stable !== es) begin
          errors++;
          $display("FAIL model_stable t=%0t actual=%b required=%b", $time, stable, es);
        end
        checks++;
        if (ports !== ep) begin
          errors++;
          $display("FAIL model_ports t=%0t actual=%b required=%b", $time, ports, ep);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1; cke = 1; raw = '0; ncyc = 8'd3; mode = '0; clr = '0;
    tick(2);
    rst = 0;
    check_en = 1;
    chk("reset_stable", stable, 4'b0000);
    chk("reset_ports", ports, 4'b0000);

    // Level mode, N=3: rise lands on the 6th edge after the change (k+N+2)
    raw = 4'b0001;
    tick(5);
    chk("lvl_before", stable, 4'b0000);
    tick(1);
    chk("lvl_stable", stable, 4'b0001);
    chk("lvl_ports", ports, 4'b0001);

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    raw = 4'b0011; tick(3); raw = 4'b0001;
    tick(10);
    chk("glitch3", stable, 4'b0001);
    raw = 4'b0011; tick(4); raw = 4'b0001;
    tick(1);
    chk("pulse4_before", stable, 4'b0001);
    tick(1);
    chk("pulse4_rise", stable, 4'b0011);
    tick(10);
    chk("pulse4_fall", stable, 4'b0001);

    // Rising-edge mode on bit2, N=0
    ncyc = 8'd0; mode = 8'b00_01_00_00;
    raw = 4'b0101;
    tick(2);
    chk("rise_before", ports, 4'b0001);
    tick(1);
    chk("rise_set", ports, 4'b0101);
    raw = 4'b0001;
    tick(3);
    chk("rise_hold_stable", stable, 4'b0001);
    chk("rise_hold_ports", ports, 4'b0101);
    clr = 4'b0100; tick(1); clr = '0;
    chk("rise_clear", ports, 4'b0001);

    // Either-edge mode on bit3: set beats coincident clear
    mode = 8'b11_01_00_00;
    raw = 4'b1001;
    tick(2);
    clr = 4'b1000; tick(1); clr = '0;
    chk("both_set_wins", ports, 4'b1001);
    clr = 4'b1000; tick(1); clr = '0;
    chk("both_clear", ports, 4'b0001);
    raw = 4'b0001;
    tick(2);
    chk("fall_before", ports, 4'b0001);
    tick(1);
    chk("fall_set", ports, 4'b1001);

    // Clock-enable freeze mid-count shifts the rise by the frozen cycles
    ncyc = 8'd3;
    raw = 4'b0011;
    tick(3);
    cke = 0;
    tick(10);
    chk("cke_frozen", stable, 4'b0001);
    cke = 1;
    tick(2);
    chk("cke_before", stable, 4'b0001);
    tick(1);
    chk("cke_rise", stable, 4'b0011);
    chk("cke_ports", ports, 4'b1011);

    // Reset mid-count, then re-qualification from scratch with raw high
    raw = 4'b0111;
    tick(3);
    rst = 1; tick(1); rst = 0;
    chk("midrst_stable", stable, 4'b0000);
    chk("midrst_ports", ports, 4'b0000);
    tick(5);
    chk("rel_before", stable, 4'b0000);
    tick(1);
    chk("rel_stable", stable, 4'b0111);
    chk("rel_ports", ports, 4'b0111);

    tick(2);
    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
